uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter among NUM_REQ independent requesters. Each requester presents a frame with a valid/ready handshake. The arbiter picks a winner, loads the frame into the transmitter, pulses tx_start, and waits for tx_done. It then reports completion with the winner's ID. It sits between client logic (command/telemetry sources) and the UART TX datapath.

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NUM_REQ requesters. A winner's frame is loaded, tx_start pulses, and the
// arbiter waits for tx_done before reporting completion with the winner's ID.
// Optional watchdog in WAIT is enabled with the macro UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned FRAME_BITS     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [FRAME_BITS-1:0]         frame_data,
   output logic                          tx_start,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic [ID_W-1:0]               grant_id,
   output logic                          arb_busy,
   output logic                          done_valid,
   output logic [ID_W-1:0]               done_id,
   output logic                          tx_timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]       scan_idx;
   logic [ID_W-1:0]       win_id;
   logic                  win_found;
   logic [FRAME_BITS-1:0] win_data;
   logic                  grant_go;
   logic                  wd_hit;

   logic [NUM_REQ-1:0]    req_ready_nxt;
   logic [FRAME_BITS-1:0] frame_data_nxt;
   logic                  tx_start_nxt;
   logic [ID_W-1:0]       grant_id_nxt;
   logic                  arb_busy_nxt;
   logic                  done_valid_nxt;
   logic [ID_W-1:0]       done_id_nxt;

   // Round-robin search: first valid requester starting at rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   // Frame mux selecting the winner's slice of the packed request bus.
   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            win_data = req_data[i*FRAME_BITS +: FRAME_BITS];
         end
      end
   end

   assign grant_go = (state == IDLE) && win_found && !tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             wd_timeout_nxt;

   // The pulse lands on the edge where the counter would reach the limit.
   assign wd_hit         = (state == WAIT) && !tx_done &&
                           (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign wd_timeout_nxt = wd_hit;

   // Watchdog counter: cleared on grant, counts WAIT cycles without tx_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt     <= '0;
         tx_timeout <= 1'b0;
      end else begin
         tx_timeout <= wd_timeout_nxt;
         if (grant_go) begin
            wd_cnt <= '0;
         end else if (state == WAIT && !tx_done) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign wd_hit             = 1'b0;
   assign tx_timeout         = 1'b0;
`endif

   // Next-state and next-output logic; pulses default low, status holds.
   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      req_ready_nxt  = '0;
      frame_data_nxt = frame_data;
      tx_start_nxt   = 1'b0;
      grant_id_nxt   = grant_id;
      arb_busy_nxt   = arb_busy;
      done_valid_nxt = 1'b0;
      done_id_nxt    = done_id;
      case (state)
         IDLE: begin
            if (grant_go) begin
               frame_data_nxt         = win_data;
               req_ready_nxt[win_id]  = 1'b1;
               tx_start_nxt           = 1'b1;
               grant_id_nxt           = win_id;
               arb_busy_nxt           = 1'b1;
               rr_ptr_nxt             = ID_W'((32'(win_id) + 1) % NUM_REQ);
               state_nxt              = WAIT;
            end
         end
         WAIT: begin
            if (tx_done) begin
               state_nxt      = IDLE;
               arb_busy_nxt   = 1'b0;
               done_valid_nxt = 1'b1;
               done_id_nxt    = grant_id;
            end else if (wd_hit) begin
               state_nxt    = IDLE;
               arb_busy_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         req_ready  <= '0;
         frame_data <= '0;
         tx_start   <= 1'b0;
         grant_id   <= '0;
         arb_busy   <= 1'b0;
         done_valid <= 1'b0;
         done_id    <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         req_ready  <= req_ready_nxt;
         frame_data <= frame_data_nxt;
         tx_start   <= tx_start_nxt;
         grant_id   <= grant_id_nxt;
         arb_busy   <= arb_busy_nxt;
         done_valid <= done_valid_nxt;
         done_id    <= done_id_nxt;
      end
   end

endmodule
